// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer FSM states and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_FRAME_BITS   = 10;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a push at full is refused
    // even if a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: write port -> FIFO -> serializer with baud divider.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CELL_DEPTH   = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  din,
    input  logic                        wr_en,
    output logic                        tx_busy,
    output logic [$clog2(CELL_DEPTH):0] level,
    output logic                        idle,
    output logic                        tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_t state, state_d;
    logic [BW-1:0] baud_cnt, baud_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shreg, shreg_d;
    logic          tx_d;
    logic          pop;
    logic          baud_last;
    logic          bit_last;
    logic [7:0]    fifo_rdata;
    logic          fifo_empty;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (CELL_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .wdata (din),
        .rdata (fifo_rdata),
        .level (level),
        .full  (tx_busy),
        .empty (fifo_empty)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_idx == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            tx       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!fifo_empty) state_d = START;
            START:   if (baud_last) state_d = DATA;
            DATA:    if (baud_last && bit_last) state_d = STOP;
            STOP:    if (baud_last) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the start bit appears on the pop edge.
    always_comb begin
        pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
        baud_d  = (state == IDLE || baud_last || state_d != state) ? '0 : baud_cnt + BW'(1);
        bit_d   = (state_d != DATA) ? '0 :
                  ((state == DATA && baud_last) ? bit_idx + 3'd1 : bit_idx);
        shreg_d = pop ? fifo_rdata :
                  ((state == DATA && baud_last) ? {1'b0, shreg[7:1]} : shreg);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign idle = fifo_empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: occupancy/drain model plus a bit-level UART receiver.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx_busy;
    logic [3:0] level;
    logic       idle;
    logic       tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_fifo #(
        .CELL_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .wr_en   (wr_en),
        .tx_busy (tx_busy),
        .level   (level),
        .idle    (idle),
        .tx      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: queued bytes plus cycles left in the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         rem = 0;

    // Receiver model output.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         rx_ferr = 0;
    bit         rx_busy = 0;
    int         rx_k = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            rx_busy = 0;
            rx_k    = 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1;
                rx_k    = 0;
                rx_t.push_back(cyc);
            end
        end else begin
            rx_k++;
            if (rx_k % CPB == CPB / 2) begin
                if (rx_k / CPB == 0) begin
                    if (tx !== 1'b0) rx_ferr++;
                end else if (rx_k / CPB <= 8) begin
                    rx_sh[rx_k / CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) rx_ferr++;
                    rx_q.push_back(rx_sh);
                    rx_busy = 0;
                end
            end
        end
    end

    task automatic model_edge(input logic we, input logic [7:0] d);
        bit was_full;
        bit do_pop;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() > 0) && (rem <= 1);
        if (do_pop) begin
            void'(mq.pop_front());
            rem = FRAME;
        end else if (rem > 0) begin
            rem--;
        end
        if (we && !was_full) begin
            mq.push_back(d);
            exp_q.push_back(d);
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d);
        wr_en = we;
        din   = d;
        @(posedge clk);
        model_edge(we, d);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (mq.size() == 0 && rem == 0) break;
            step(1'b0, 8'h00);
        end
        repeat (3) step(1'b0, 8'h00);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        rx_ferr = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL rst_tx got %b want 1", tx); end
        checks++; if (level !== 4'd0)   begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", tx_busy); end
        checks++; if (idle !== 1'b1)    begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
        reset = 1'b1;
        step(1'b0, 8'h00);
        @(negedge clk);
        checks++; if (tx !== 1'b1 || idle !== 1'b1)
            begin errors++; $display("FAIL post_rst tx=%b idle=%b want 1 1", tx, idle); end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic       want;
        d = 8'hA5;
        clear_obs();
        step(1'b1, d);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL sb_tx_e0 got %b want 1", tx); end
        for (int j = 0; j < FRAME; j++) begin
            step(1'b0, 8'h00);
            @(negedge clk);
            if (j / CPB == 0)      want = 1'b0;
            else if (j / CPB == 9) want = 1'b1;
            else                   want = d[j / CPB - 1];
            checks++; if (tx !== want)
                begin errors++; $display("FAIL sb_bit cycle %0d got %b want %b", j, tx, want); end
        end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL sb_idle_stop got %b want 0", idle); end
        step(1'b0, 8'h00);
        @(negedge clk);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL sb_idle_end got %b want 1", idle); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== d || rx_ferr != 0)
            begin errors++; $display("FAIL sb_rx got %0d bytes ferr %0d want 1 byte a5", rx_q.size(), rx_ferr); end
    endtask

    task automatic test_burst_full();
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i));
            @(negedge clk);
            checks++; if (level !== 4'(mq.size()) || tx_busy !== (mq.size() == DEPTH))
                begin errors++; $display("FAIL burst_occ wr %0d level %0d busy %b want %0d %b",
                      i, level, tx_busy, mq.size(), mq.size() == DEPTH); end
        end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL burst_full got %b want 1", tx_busy); end
        drain(12 * FRAME);
        checks++; if (rx_q.size() != 9 || rx_ferr != 0)
            begin errors++; $display("FAIL burst_count got %0d ferr %0d want 9 0", rx_q.size(), rx_ferr); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(i))
                begin errors++; $display("FAIL burst_data %0d got %h want %h", i, rx_q[i], 8'(i)); end
        end
        for (int i = 1; i < rx_t.size(); i++) begin
            checks++; if (rx_t[i] - rx_t[i-1] != FRAME)
                begin errors++; $display("FAIL burst_gap %0d got %0d want %0d", i, rx_t[i] - rx_t[i-1], FRAME); end
        end
        if (rx_t.size() == 9) begin
            checks++; if (rx_t[8] - rx_t[0] + FRAME != 360)
                begin errors++; $display("FAIL burst_span got %0d want 360", rx_t[8] - rx_t[0] + FRAME); end
        end
    endtask

    task automatic test_simul_full();
        clear_obs();
        for (int i = 0; i < 9; i++) step(1'b1, 8'h50 + 8'(i));
        repeat (FRAME - 8) step(1'b0, 8'h00);
        @(negedge clk);
        checks++; if (level !== 4'd8 || tx_busy !== 1'b1)
            begin errors++; $display("FAIL sim_pre level %0d busy %b want 8 1", level, tx_busy); end
        step(1'b1, 8'hEE);
        @(negedge clk);
        checks++; if (level !== 4'd7 || tx_busy !== 1'b0)
            begin errors++; $display("FAIL sim_pop level %0d busy %b want 7 0", level, tx_busy); end
        step(1'b1, 8'hEF);
        @(negedge clk);
        checks++; if (level !== 4'd8 || tx_busy !== 1'b1)
            begin errors++; $display("FAIL sim_refill level %0d busy %b want 8 1", level, tx_busy); end
        drain(12 * FRAME);
        checks++; if (rx_q.size() != 10)
            begin errors++; $display("FAIL sim_count got %0d want 10", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== ((i == 9) ? 8'hEF : 8'h50 + 8'(i)))
                begin errors++; $display("FAIL sim_data %0d got %h", i, rx_q[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] bytes[$];
        clear_obs();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
        drain(8 * FRAME);
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            bytes.push_back(8'($urandom));
            step(1'b1, bytes[i]);
        end
        drain(10 * FRAME);
        checks++; if (rx_q.size() != 8 || rx_ferr != 0)
            begin errors++; $display("FAIL wrap_count got %0d ferr %0d want 8 0", rx_q.size(), rx_ferr); end
        for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== bytes[i])
                begin errors++; $display("FAIL wrap_data %0d got %h want %h", i, rx_q[i], bytes[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d0;
        bit         saw_low;
        d0 = 8'hF7;
        clear_obs();
        step(1'b1, d0);
        for (int i = 1; i < 4; i++) step(1'b1, 8'h10 + 8'(i));
        repeat (15) step(1'b0, 8'h00);
        checks++; if (tx !== d0[3])
            begin errors++; $display("FAIL rmf_bit3 got %b want %b", tx, d0[3]); end
        #2 reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL rmf_tx got %b want 1", tx); end
        checks++; if (level !== 4'd0)   begin errors++; $display("FAIL rmf_level got %0d want 0", level); end
        checks++; if (idle !== 1'b1)    begin errors++; $display("FAIL rmf_idle got %b want 1", idle); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got %b want 0", tx_busy); end
        mq.delete();
        rem = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_obs();
        saw_low = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 8'h00);
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1;
        end
        checks++; if (saw_low || rx_q.size() != 0)
            begin errors++; $display("FAIL rmf_quiet low %0d frames %0d want 0 0", saw_low, rx_q.size()); end
        step(1'b1, 8'h3C);
        drain(3 * FRAME);
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || rx_ferr != 0)
            begin errors++; $display("FAIL rmf_after got %0d bytes ferr %0d want 1 byte 3c", rx_q.size(), rx_ferr); end
    endtask

    task automatic test_random();
        int  duty;
        bit  we;
        int  bad_occ;
        clear_obs();
        duty = 50;
        bad_occ = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) duty = $urandom_range(5, 100);
            @(negedge clk);
            checks++; if (level !== 4'(mq.size()) || tx_busy !== (mq.size() == DEPTH)) begin
                errors++;
                if (bad_occ < 5) $display("FAIL rnd_occ cyc %0d level %0d busy %b want %0d %b",
                                          i, level, tx_busy, mq.size(), mq.size() == DEPTH);
                bad_occ++;
            end
            we = ($urandom_range(0, 99) < duty);
            step(we, 8'($urandom));
        end
        drain(12 * FRAME);
        checks++; if (rx_q.size() != exp_q.size() || rx_ferr != 0)
            begin errors++; $display("FAIL rnd_count got %0d ferr %0d want %0d 0", rx_q.size(), rx_ferr, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i])
                begin errors++; $display("FAIL rnd_data %0d got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_full();
        test_simul_full();
        test_wrap();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: an 8-bit write port feeds a CELL_DEPTH-entry FIFO that drains into an 8N1 serializer with an internal baud divider. It sits directly downstream of the APB UART slave and replaces the unbuffered transmit path. The APB slave keeps using `tx_busy` as "not ready", so the CPU stalls only when the FIFO is full, not for every character.

## Interface
- `CELL_DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 434: clk cycles per serial bit (50 MHz / 115200); ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `din`  in  8  byte to transmit.
- `wr_en`  in  1  write strobe; one byte per cycle in which it is high.
- `tx_busy`  out  1  FIFO full; a write in this cycle is dropped.
- `level`  out  $clog2(CELL_DEPTH)+1  current FIFO occupancy.
- `idle`  out  1  FIFO empty and serializer in IDLE.
- `tx`  out  1  serial line, idle high, registered.

## Operation
- **Write.** `wr_en` with `tx_busy`=0 stores `din` at the write pointer; pointers wrap modulo CELL_DEPTH.
  - `wr_en` with `tx_busy`=1 is silently dropped. FIFO state and `level` are unchanged.
- **Pop.** The serializer pops only when `level`>0 and the FSM is IDLE, or at the last cycle of STOP.
- **FSM states:**
  - IDLE: `tx`=1; pop if non-empty, then go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles; then go to START with a pop if non-empty, else to IDLE.
- **Counters.** A baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state change. A 3-bit counter tracks the DATA bit index.
- **Simultaneous write and pop:**
  - Both take effect and `level` is unchanged.
  - When full, the write is still dropped, because `tx_busy` is evaluated before the pop.
  - When empty, no pop occurs, because `level` is 0 at the sample edge.
- **Derived outputs.**
  - `tx_busy` = (`level`==CELL_DEPTH), combinational from the registered count.
  - `idle` = (`level`==0) && state==IDLE.
- **Reset values:** `tx`=1, state IDLE, pointers 0, `level` 0, `tx_busy` 0, `idle` 1.
  - Reset asserted mid-frame drives `tx` high immediately (asynchronous), truncates the frame and discards all FIFO contents.

## Timing
- Write latency:
  - Edge E0 samples `wr_en` into an empty, idle block.
  - Edge E1 pops the byte, enters START and drives `tx` low.
  - Write-to-start-bit latency is 2 edges.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames have zero idle cycles: the STOP of byte n is followed directly by the START of byte n+1.
- `level` updates on the edge after the write or pop.
- `tx_busy` deasserts in the cycle after the pop that frees a slot.
- Sustained throughput is one byte per 10×CLKS_PER_BIT cycles. Bursts of up to CELL_DEPTH+1 bytes are absorbed: one in the serializer plus CELL_DEPTH in the FIFO.

## Structure
- Shared package `uart_pkg`:
  - FSM state localparams: IDLE, START, DATA, STOP.
  - `UART_FRAME_BITS`=10.
  - `UART_DATA_BITS`=8.
  - Default `CLKS_PER_BIT`.
- Sub-module `uart_sync_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, wdata, rdata (first-word-fall-through), level, full, empty.
  - Reusable later for the RX buffer.
- Top level holds the serializer FSM, baud counter, bit counter and shift register.

## Test plan
All scenarios use CLKS_PER_BIT=4 and CELL_DEPTH=8.
- **Single byte.** Reset, then write 0xA5.
  - `tx` goes low 2 edges after the write.
  - Bits follow LSB first, 4 cycles each: 0,1,0,1,0,0,1,0,1,1 (start, data, stop).
  - `idle` returns to 1 after 40 cycles.
- **Burst / full.** Write 10 bytes (0x00..0x09) on consecutive cycles.
  - `tx_busy` rises after byte 9 is accepted, so byte 0x09 is dropped.
  - The line carries 0x00..0x08 back-to-back with no idle gap: 360 cycles.
- **Simultaneous write and pop at full.** Hold `wr_en` with `tx_busy`=1 during the pop edge.
  - The write is dropped and `level` goes 8→7.
  - The next cycle's write is accepted and `level` returns to 8.
- **Wrap-around.** Write 5, let 5 drain, then write 8.
  - All 8 bytes are transmitted in order with correct data across the pointer wrap.
- **Reset mid-frame.** Assert reset during DATA bit 3 with 3 bytes queued.
  - `tx`=1 immediately, `level`=0, `idle`=1.
  - No further frames after release.
  - A new write of 0x3C transmits correctly.
- **Reference-model check.** Random writes with a random `wr_en` duty.
  - A bit-level UART receiver model decodes every accepted byte in order.
  - Dropped writes occur only while `tx_busy`=1.
